uart_key_ctrl: RTL

UART_KEY_CTRL -- requirements
Module: uart_key_ctrl

---
 rtl/uart_pkg.sv | 22 ++
 rtl/key_fifo.sv | 58 +++++
 rtl/uart_key_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared FSM encoding and ASCII digit bounds for uart_key_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      PUSH   = 2'd2,
      DROP   = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_0            = 8'h30;
   localparam logic [7:0] ASCII_9            = 8'h39;
   localparam int         DEFAULT_FIFO_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/key_fifo.sv
// ============================================================================
// key_fifo : small FIFO with full/empty flags; push is accepted when full if
//            a pop happens in the same cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is masked while empty so the output reads zero after reset
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_key_ctrl.sv
// ============================================================================
// uart_key_ctrl : filters UART bytes to decimal digits and queues them as keys.
//                 UART_KEY_PARITY_DROP_EN: drop digits received with bad parity.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_key_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_ascii,
   input  logic             rx_valid,
   input  logic             rx_parity_error,
   output logic [3:0]       key_code,
   output logic             key_valid,
   input  logic             key_ready,
   output logic [CNT_W-1:0] parity_err_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             overflow
);

`ifdef UART_KEY_PARITY_DROP_EN
   localparam logic PARITY_DROP = 1'b1;
`else
   localparam logic PARITY_DROP = 1'b0;
`endif

   state_t     state;
   logic [7:0] hold_byte;
   logic       hold_par;
   logic       is_digit;
   logic       accept;
   logic       push;
   logic       full;
   logic       empty;
   logic       busy_drop;
   logic       full_drop;
   logic [1:0] drop_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign is_digit  = (hold_byte >= ASCII_0) && (hold_byte <= ASCII_9);
   assign accept    = is_digit && !(PARITY_DROP && hold_par);
   assign push      = (state == PUSH);
   assign key_valid = !empty;
   assign busy_drop = rx_valid && (state != IDLE);
   assign full_drop = push && full && !(key_ready && key_valid);
   assign drop_inc  = {1'b0, busy_drop} + {1'b0, full_drop};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         hold_byte      <= '0;
         hold_par       <= 1'b0;
         parity_err_cnt <= '0;
         drop_cnt       <= '0;
         overflow       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  hold_byte <= rx_ascii;
                  hold_par  <= rx_parity_error;
                  state     <= DECODE;
               end
            end
            DECODE:  state <= accept ? PUSH : DROP;
            PUSH:    state <= IDLE;
            DROP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         parity_err_cnt <= sat_add(parity_err_cnt, {1'b0, (state == DECODE) && hold_par});
         drop_cnt       <= sat_add(drop_cnt, drop_inc);
         if (full_drop) overflow <= 1'b1;
      end
   end

   // ASCII '0'..'9' carry the digit value in their low nibble
   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_key_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (hold_byte[3:0]),
      .pop   (key_ready),
      .rdata (key_code),
      .full  (full),
      .empty (empty)
   );

endmodule

`default_nettype wire
